// File: rtl/io_defs_pkg.sv
// Shared constants for the IO board input front end.
package io_defs;

  localparam logic        PB_PRESSED              = 1'b0;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned IO_N_PB                 = 4;
  localparam int unsigned IO_N_DSW                = 8;

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// Single-bit synchroniser plus debouncer with registered one-cycle rise/fall pulses.
module debounce_bit
  import io_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      db   <= 1'b1;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Accept the new level and flag its direction on the same edge.
        db   <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Pushbutton / DIP-switch conditioner: per-bit debounce, edge pulses and button priority encode.
module io_input_conditioner
  import io_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned N_PB            = IO_N_PB,
  parameter int unsigned N_DSW           = IO_N_DSW
) (
  input  logic             M_CLOCK,
  input  logic             M_RESET_N,
  input  logic [N_PB-1:0]  IO_PB,
  input  logic [N_DSW-1:0] IO_DSW,
  output logic [N_PB-1:0]  PB_DB,
  output logic [N_DSW-1:0] DSW_DB,
  output logic [N_PB-1:0]  PB_PRESS,
  output logic [N_PB-1:0]  PB_RELEASE,
  output logic             DSW_CHANGED,
  output logic             PB_ANY,
  output logic [1:0]       PB_ACTIVE
);

  logic [N_DSW-1:0] dsw_rise;
  logic [N_DSW-1:0] dsw_fall;

  // Buttons are active-low: a falling debounced level is a press.
  for (genvar i = 0; i < N_PB; i++) begin : g_pb
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk  (M_CLOCK),
      .rst_n(M_RESET_N),
      .raw  (IO_PB[i]),
      .db   (PB_DB[i]),
      .rise (PB_RELEASE[i]),
      .fall (PB_PRESS[i])
    );
  end

  for (genvar j = 0; j < N_DSW; j++) begin : g_dsw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk  (M_CLOCK),
      .rst_n(M_RESET_N),
      .raw  (IO_DSW[j]),
      .db   (DSW_DB[j]),
      .rise (dsw_rise[j]),
      .fall (dsw_fall[j])
    );
  end

  assign DSW_CHANGED = |(dsw_rise | dsw_fall);
  assign PB_ANY      = ~&PB_DB;

  always_comb begin
    logic found;
    PB_ACTIVE = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N_PB; k++) begin
      if (!found && PB_DB[k] == PB_PRESSED) begin
        PB_ACTIVE = 2'(k);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (6-edge latency).
module tb_io_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] io_pb;
  logic [7:0] io_dsw;
  logic [3:0] pb_db;
  logic [7:0] dsw_db;
  logic [3:0] pb_press;
  logic [3:0] pb_release;
  logic       dsw_changed;
  logic       pb_any;
  logic [1:0] pb_active;

  int total;
  int bad;

  typedef struct {
    logic [3:0]  pb;
    logic [7:0]  dsw;
    logic [23:0] exp;
  } vec_t;

  vec_t vq[$];

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2),
    .N_PB           (4),
    .N_DSW          (8)
  ) dut (
    .M_CLOCK    (clk),
    .M_RESET_N  (rst_n),
    .IO_PB      (io_pb),
    .IO_DSW     (io_dsw),
    .PB_DB      (pb_db),
    .DSW_DB     (dsw_db),
    .PB_PRESS   (pb_press),
    .PB_RELEASE (pb_release),
    .DSW_CHANGED(dsw_changed),
    .PB_ANY     (pb_any),
    .PB_ACTIVE  (pb_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [23:0] pack(input logic [3:0] pdb, input logic [7:0] ddb,
                                       input logic [3:0] pr, input logic [3:0] rl,
                                       input logic ch, input logic any, input logic [1:0] act);
    return {pdb, ddb, pr, rl, ch, any, act};
  endfunction

  function automatic logic [23:0] outs();
    return {pb_db, dsw_db, pb_press, pb_release, dsw_changed, pb_any, pb_active};
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic void add(input logic [3:0] pb, input logic [7:0] dsw, input logic [23:0] exp);
    vec_t v;
    v.pb  = pb;
    v.dsw = dsw;
    v.exp = exp;
    vq.push_back(v);
  endfunction

  // Five quiet edges at the old level, the update edge with pulses, then one settled edge.
  function automatic void add_phase(input logic [3:0] pb, input logic [7:0] dsw,
                                    input logic [3:0] o_pdb, input logic [7:0] o_ddb,
                                    input logic o_any, input logic [1:0] o_act,
                                    input logic [3:0] n_pdb, input logic [7:0] n_ddb,
                                    input logic n_any, input logic [1:0] n_act,
                                    input logic [3:0] pr, input logic [3:0] rl, input logic ch);
    for (int k = 1; k <= 5; k++) add(pb, dsw, pack(o_pdb, o_ddb, 4'h0, 4'h0, 1'b0, o_any, o_act));
    add(pb, dsw, pack(n_pdb, n_ddb, pr, rl, ch, n_any, n_act));
    add(pb, dsw, pack(n_pdb, n_ddb, 4'h0, 4'h0, 1'b0, n_any, n_act));
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    add_phase(4'hE, 8'hFF, 4'hF, 8'hFF, 1'b0, 2'd0, 4'hE, 8'hFF, 1'b1, 2'd0, 4'h1, 4'h0, 1'b0);
    add_phase(4'hF, 8'hFF, 4'hE, 8'hFF, 1'b1, 2'd0, 4'hF, 8'hFF, 1'b0, 2'd0, 4'h0, 4'h1, 1'b0);
    add_phase(4'h3, 8'hFF, 4'hF, 8'hFF, 1'b0, 2'd0, 4'h3, 8'hFF, 1'b1, 2'd2, 4'hC, 4'h0, 1'b0);
    add_phase(4'hF, 8'hFF, 4'h3, 8'hFF, 1'b1, 2'd2, 4'hF, 8'hFF, 1'b0, 2'd0, 4'h0, 4'hC, 1'b0);
    add_phase(4'hF, 8'h5A, 4'hF, 8'hFF, 1'b0, 2'd0, 4'hF, 8'h5A, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);

    // Reset values
    rst_n  = 1'b0;
    io_pb  = 4'hF;
    io_dsw = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset", outs(), pack(4'hF, 8'hFF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: single press/release, dual press/release, DIP change
    for (int i = 0; i < vq.size(); i++) begin
      io_pb  = vq[i].pb;
      io_dsw = vq[i].dsw;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), outs(), vq[i].exp);
    end

    // Bounce on PB[1] shorter than the debounce window
    for (int c = 0; c < 20; c++) begin
      io_pb = ((c / 2) % 2 == 0) ? 4'hD : 4'hF;
      @(posedge clk);
      #1;
      check($sformatf("glitch[%0d]", c), outs(), pack(4'hF, 8'h5A, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
    end
    io_pb = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("glitch_tail[%0d]", c), outs(), pack(4'hF, 8'h5A, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
    end

    // Reset in the middle of a press count, button held through release
    io_pb  = 4'hE;
    io_dsw = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset", outs(), pack(4'hF, 8'hFF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    @(negedge clk);
    check("in_reset", outs(), pack(4'hF, 8'hFF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k < 6)
        check($sformatf("post_reset[%0d]", k), outs(), pack(4'hF, 8'hFF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
      else if (k == 6)
        check("post_reset_press", outs(), pack(4'hE, 8'hFF, 4'h1, 4'h0, 1'b0, 1'b1, 2'd0));
      else
        check("post_reset_settle", outs(), pack(4'hE, 8'hFF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
